// File: rtl/writer_pkg.sv
// ============================================================================
//  Module   : writer_pkg
//  Brief    : Shared defaults and the parity helper for the parity writer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package writer_pkg;

    // Default payload width, counter width and buffer depth
    localparam int DWIDTH_DEF = 10;
    localparam int VWIDTH_DEF = 4;
    localparam int DEPTH_DEF  = 4;

    // Widest payload the parity helper handles; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W  = 64;

    // Parity bit for a word: even mode gives ^data, odd mode inverts it
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data,
                                        input logic                 odd);
        return (^data) ^ odd;
    endfunction

endpackage : writer_pkg

`default_nettype wire

// File: rtl/parity_fifo.sv
// ============================================================================
//  Module   : parity_fifo
//  Brief    : Circular word buffer with registered occupancy and full/empty
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_fifo
    import writer_pkg::*;
#(
    parameter int WIDTH = DWIDTH_DEF + 1,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic             w_push;
    logic             w_pop;

    // Flags come straight from the registered occupancy
    assign full   = (r_occ == C_DEPTH);
    assign empty  = (r_occ == '0);
    assign w_push = wr_en & ~full & ~clear;
    assign w_pop  = rd_en & ~empty & ~clear;

    // Head word, forced to zero whenever the buffer holds nothing
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: no reset needed, empty gating masks stale contents
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

endmodule : parity_fifo

`default_nettype wire

// File: rtl/parity_writer.sv
// ============================================================================
//  Module   : parity_writer
//  Brief    : Appends a parity bit to each accepted word and buffers it;
//             tracks accepted-word count and a sticky overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_writer
    import writer_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int VWIDTH = VWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic              parity_odd,
    input  logic [DWIDTH-1:0] in,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DWIDTH:0]   out,
    output logic [VWIDTH-1:0] cnt,
    output logic              overflow
);

    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_pop;
    logic            w_par;
    logic [DWIDTH:0] w_word;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_accept  = start & in_ready & ~clear;
    assign w_pop     = out_valid & out_ready & ~clear;
    assign w_par     = parity_bit(PAR_MAX_W'(in), parity_odd);
    assign w_word    = {w_par, in};

    parity_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (w_accept),
        .wr_data (w_word),
        .rd_en   (w_pop),
        .rd_data (out),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Accepted-word counter, wraps at 2^VWIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (w_accept) begin
            cnt <= cnt + VWIDTH'(1);
        end
    end

    // Sticky overflow: a write offered while full, even if a pop happens too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (start && w_full) begin
            overflow <= 1'b1;
        end
    end

endmodule : parity_writer

`default_nettype wire
